// File: rtl/instr_loader_pkg.sv
// instr_loader_pkg: shared widths and FSM encoding for the program loader
package instr_loader_pkg;
    localparam int INSTR_BIT_DEF = 10;
    typedef enum logic [1:0] {
        LD_IDLE  = 2'd0,
        LD_LOAD  = 2'd1,
        LD_START = 2'd2,
        LD_READY = 2'd3
    } ld_state_e;
endpackage

// File: rtl/instr_loader_if.sv
// instr_loader_if: host byte-stream valid/ready handshake
interface instr_loader_if;
    logic       in_valid;
    logic       in_ready;
    logic       in_last;
    logic [7:0] in_byte;
    modport master (output in_valid, in_byte, in_last, input in_ready);
    modport slave  (input in_valid, in_byte, in_last, output in_ready);
endinterface

// File: rtl/instr_ram.sv
// instr_ram: instruction storage with synchronous write and combinational read
module instr_ram #(
    parameter int AW    = 8,
    parameter int DEPTH = 2**AW
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);
    logic [31:0] mem [DEPTH];
    // store a word on the edge that presents it
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    assign rdata = mem[raddr];
endmodule

// File: rtl/instr_loader.sv
// instr_loader: packs host bytes into words, fills instruction RAM, pulses St when done
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int INSTR_BIT = INSTR_BIT_DEF,
    parameter int DEPTH     = 2**(INSTR_BIT-2)
) (
    input  logic                 CLK,
    input  logic                 RST,
    instr_loader_if.slave        host,
    input  logic                 reload,
    input  logic [INSTR_BIT-1:0] pc,
    output logic [31:0]          instruction,
    output logic                 St,
    output logic [INSTR_BIT-2:0] word_count,
    output logic                 error
);
    localparam int AW = INSTR_BIT - 2;
    localparam int CW = INSTR_BIT - 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    ld_state_e     state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [23:0]   word_q, word_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d, st_q, st_d;
    logic          acc, fin, eow, we;
    logic [31:0]   wdata, rdata;
    logic [AW-1:0] ridx;
    logic          unused_pc;

    assign host.in_ready = state_q == LD_IDLE || state_q == LD_LOAD;
    assign acc   = host.in_valid & host.in_ready;
    assign fin   = acc & host.in_last;
    assign eow   = idx_q == 2'd3 || host.in_last;
    assign wdata = {8'h00, word_q} | ({24'h0, host.in_byte} << {idx_q, 3'b000});
    assign we    = acc & eow & (cnt_q != FULL);
    assign ridx  = pc[INSTR_BIT-1:2];
    assign unused_pc = ^pc[1:0];

    instr_ram #(.AW(AW), .DEPTH(DEPTH)) u_ram (
        .clk   (CLK),
        .we    (we),
        .waddr (cnt_q[AW-1:0]),
        .wdata (wdata),
        .raddr (ridx),
        .rdata (rdata)
    );

    // next-state: byte packing, commit counting, error tracking and FSM sequencing
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        st_d    = 1'b0;
        if (acc) begin
            idx_d   = fin ? 2'd0 : idx_q + 2'd1;
            word_d  = eow ? 24'h0 : wdata[23:0];
            cnt_d   = cnt_q + CW'(we);
            err_d   = err_q | (cnt_q == FULL) | (fin & idx_q != 2'd3);
            state_d = fin ? LD_START : LD_LOAD;
            st_d    = fin;
        end
        if (state_q == LD_START) state_d = LD_READY;
        if (state_q == LD_READY && reload) begin
            state_d = LD_IDLE;
            idx_d   = 2'd0;
            word_d  = 24'h0;
            cnt_d   = '0;
            err_d   = 1'b0;
        end
    end

    // FSM and registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= LD_IDLE;
            idx_q   <= 2'd0;
            word_q  <= 24'h0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            st_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            st_q    <= st_d;
        end
    end

    assign instruction = (state_q == LD_READY && {1'b0, ridx} < cnt_q) ? rdata : 32'h0;
    assign St          = st_q;
    assign word_count  = cnt_q;
    assign error       = err_q;
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: randomized directed checks of instr_loader against a word-level model
module tb_instr_loader;
    localparam int IB = 4;
    localparam int DEPTH = 4;

    logic          CLK = 0;
    logic          RST = 1;
    logic          reload = 0;
    logic [IB-1:0] pc = 0;
    logic [31:0]   instruction;
    logic          St;
    logic [IB-2:0] word_count;
    logic          error;

    instr_loader_if bus ();

    instr_loader #(.INSTR_BIT(IB)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .host        (bus),
        .reload      (reload),
        .pc          (pc),
        .instruction (instruction),
        .St          (St),
        .word_count  (word_count),
        .error       (error)
    );

    always #5 CLK = ~CLK;

    int compared = 0;
    int mismatched = 0;
    int st_cnt = 0;
    logic [31:0] model_mem [DEPTH];
    int exp_wc;
    logic exp_err;
    logic [7:0] bq[$];

    always @(negedge CLK) if (St) st_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [7:0] q[$]);
        int n;
        logic [31:0] v;
        n = q.size();
        exp_wc = 0;
        exp_err = (n % 4) != 0;
        for (int w = 0; w * 4 < n; w++) begin
            if (w >= DEPTH) begin
                exp_err = 1;
                break;
            end
            v = 0;
            for (int k = 0; k < 4; k++) if (w * 4 + k < n) v[8*k +: 8] = q[w*4+k];
            model_mem[w] = v;
            exp_wc++;
        end
    endtask

    task automatic load(input logic [7:0] q[$], input bit gaps);
        int s0;
        s0 = st_cnt;
        model(q);
        for (int i = 0; i < q.size(); i++) begin
            if (gaps) repeat ($urandom_range(0, 3)) begin
                bus.in_valid = 0;
                reload = 1'($urandom);
                @(posedge CLK); #1;
            end
            bus.in_valid = 1;
            bus.in_byte  = q[i];
            bus.in_last  = (i == q.size() - 1);
            reload = 1'($urandom);
            pc = IB'($urandom);
            #1;
            chk("ready_load", bus.in_ready, 1);
            chk("instr_load", instruction, 0);
            @(posedge CLK); #1;
        end
        bus.in_valid = 0;
        bus.in_last  = 0;
        reload = 1;
        #1;
        chk("st_high", St, 1);
        chk("ready_start", bus.in_ready, 0);
        @(posedge CLK); #1;
        reload = 0;
        #1;
        chk("st_low", St, 0);
        chk("ready_ready", bus.in_ready, 0);
        repeat (3) @(posedge CLK);
        #1;
        chk("st_pulses", st_cnt - s0, 1);
        chk("word_count", word_count, exp_wc);
        chk("error", error, exp_err);
        for (int p = 0; p < 2**IB; p++) begin
            pc = IB'(p);
            #1;
            chk($sformatf("instr_pc%0d", p), instruction, (p / 4 < exp_wc) ? model_mem[p/4] : 32'h0);
        end
    endtask

    task automatic do_reload();
        @(posedge CLK); #1;
        reload = 1;
        @(posedge CLK); #1;
        reload = 0;
        #1;
        chk("rl_ready", bus.in_ready, 1);
        chk("rl_error", error, 0);
        chk("rl_wc", word_count, 0);
        chk("rl_instr", instruction, 0);
        chk("rl_st", St, 0);
    endtask

    initial begin
        int s0;
        bus.in_valid = 0;
        bus.in_byte  = 0;
        bus.in_last  = 0;
        repeat (2) @(posedge CLK);
        #1;
        pc = IB'($urandom);
        #1;
        chk("rst_ready", bus.in_ready, 1);
        chk("rst_st", St, 0);
        chk("rst_error", error, 0);
        chk("rst_wc", word_count, 0);
        chk("rst_instr", instruction, 0);
        RST = 0;
        @(posedge CLK); #1;

        bq = {};
        for (int i = 1; i <= 8; i++) bq.push_back(8'(i));
        load(bq, 0);
        chk("w1_fixed", model_mem[1], 32'h08070605);

        do_reload();
        bq = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
        load(bq, 0);
        chk("pad_fixed", model_mem[1], 32'h0000FFEE);

        do_reload();
        bq = {};
        for (int i = 0; i < 20; i++) bq.push_back(8'($urandom));
        load(bq, 0);

        do_reload();
        bq = {};
        for (int i = 0; i < 12; i++) bq.push_back(8'($urandom));
        load(bq, 0);
        do_reload();
        load(bq, 1);

        do_reload();
        s0 = st_cnt;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1;
            bus.in_byte  = 8'($urandom);
            bus.in_last  = 0;
            @(posedge CLK); #1;
        end
        bus.in_valid = 0;
        #2 RST = 1;
        #1;
        chk("mid_rst_ready", bus.in_ready, 1);
        chk("mid_rst_wc", word_count, 0);
        chk("mid_rst_st", St, 0);
        #1 RST = 0;
        @(posedge CLK); #1;
        chk("mid_rst_no_st", st_cnt - s0, 0);
        bq = {8'h11, 8'h22, 8'h33, 8'h44};
        load(bq, 1);
        chk("rst_w0_fixed", model_mem[0], 32'h44332211);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end
endmodule

// File: doc/instr_loader.md
# instr_loader

Program-load front end for the processor. It receives a byte stream from the host over a valid/ready handshake and assembles it into 32-bit instructions. It stores those instructions in its own instruction RAM and serves them to the fetch path through a combinational read port addressed by `pc`. When the program is complete it issues the one-cycle `St` pulse that the controller uses to enable execution.

## Interface
Parameters:
- `INSTR_BIT`, default `` `INSTR_BIT `` (from CONSTANT.v): width of `pc`, a byte address.
- `DEPTH`, default `2**(INSTR_BIT-2)`: number of 32-bit words in the RAM.

Ports:
- `CLK`  in  1  single clock; all state changes on posedge.
- `RST`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  host byte valid.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `in_byte`  in  8  program byte.
- `in_last`  in  1  qualifies the final byte of the program; sampled with `in_valid`.
- `reload`  in  1  one-cycle request to start a new load.
- `pc`  in  INSTR_BIT  fetch byte address.
- `instruction`  out  32  word at `pc[INSTR_BIT-1:2]`.
- `St`  out  1  one-cycle start pulse to the controller.
- `word_count`  out  INSTR_BIT-1  number of words committed in the current load.
- `error`  out  1  sticky; set on a padded last word or on overflow.

## Operation
- The FSM has four states: IDLE, LOAD, START, READY.
- IDLE:
  - `in_ready`=1.
  - The first accepted byte moves the FSM to LOAD.
- LOAD:
  - `in_ready`=1.
  - A byte is accepted when `in_valid & in_ready`.
  - Bytes are packed little-endian: byte k of a word goes to bits `[8k+7:8k]`.
  - A 2-bit `byte_idx` selects the lane.
  - On the 4th byte, the completed word is written to `mem[wr_ptr]` on that same clock edge, `wr_ptr` increments and `word_count` increments.
- Last byte:
  - An accepted byte with `in_last`=1 finishes the load.
  - If `byte_idx`≠3, the unfilled upper bytes are written as 0, the partial word is committed and `error` is set.
  - The FSM then moves to START.
- START:
  - Lasts one cycle, with `St`=1 and `in_ready`=0.
  - The FSM then moves to READY.
- READY:
  - `in_ready`=0.
  - `instruction` = `mem[pc[INSTR_BIT-1:2]]` when that index < `word_count`, else 32'h0 (treated by the decoder as a no-op).
  - `reload` moves the FSM to IDLE and clears `wr_ptr`, `byte_idx`, `word_count` and `error`. RAM contents are not cleared.
- In every state other than READY, `instruction` = 32'h0.
- Overflow:
  - When `wr_ptr`==DEPTH, further bytes are still accepted (so the host does not hang), but they are discarded and `error` is set.
  - `in_last` still moves the FSM to START.
- `reload` is ignored in IDLE, LOAD and START.
- `pc[1:0]` is ignored.

## Timing
- Reset values:
  - FSM=IDLE; `in_ready`=1 (combinational from IDLE state).
  - `St`=0, `error`=0, `word_count`=0, `instruction`=0.
  - RAM is not reset.
- Reset mid-load returns immediately to IDLE. The partial word is lost, and committed words are invalidated via `word_count`=0.
- Throughput is one byte per cycle, with no bubbles between words.
- Write latency is 0: the word is visible in RAM from the edge that accepts its 4th byte.
- `St` is asserted in the cycle after the edge that accepts the `in_last` byte. It is registered, lasts exactly one cycle and never repeats without `reload`.
- The read path is combinational, so `instruction` follows `pc` in the same cycle once in READY.
- `in_valid` may drop between bytes at any time; `byte_idx` holds its value.

## Structure
- CONSTANT.v:
  - `` `INSTR_BIT `` (existing).
  - Add localparam-style defines for the FSM encodings: `` `LD_IDLE ``, `` `LD_LOAD ``, `` `LD_START ``, `` `LD_READY `` (2 bits).
- One sub-module, `instr_ram`: DEPTH×32 array with one synchronous write port and one combinational read port. It is reused wherever instruction storage is needed.
- The FSM, byte packer and counters stay in `instr_loader`.

## Test plan
- Load 8 bytes 01..08 with `in_last` on 08, at one byte per cycle:
  - `mem[0]`=32'h04030201 and `mem[1]`=32'h08070605.
  - `St` is high exactly one cycle, the cycle after byte 08.
  - `word_count`=2, `error`=0.
  - pc=4 gives 32'h08070605; pc=8 gives 0.
- Load 6 bytes AA BB CC DD EE FF (last on FF):
  - `mem[1]`=32'h0000FFEE.
  - `error`=1, `word_count`=2, `St` pulses once.
- Overflow with DEPTH=4: send 20 bytes:
  - Words 0..3 are stored; bytes 17..20 are accepted and discarded.
  - `error`=1, `word_count`=4, `St` pulses once.
- Random `in_valid` gaps during a 12-byte load: RAM contents are identical to the gap-free run.
- Assert `RST` after 5 bytes, then load 4 bytes 11 22 33 44 (last):
  - `mem[0]`=32'h44332211.
  - `word_count`=1.
  - No `St` is seen before the second load.
- After READY, pulse `reload` and load 4 new bytes:
  - `error` clears, `in_ready` returns to 1, and a second `St` pulse occurs.
  - While in IDLE/LOAD, `instruction`=0.
